// File: rtl/game_state_mux.sv
// Master-side transmit mux: snapshots the game state once per frame and sends it as five
// tagged 16-bit words ({tag, payload}) to the UART 16-to-8 converter.
module game_state_mux #(
  parameter int unsigned FRAME_GAP = 65000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] pl1_posx,
  input  logic [11:0] pl1_posy,
  input  logic [11:0] ball_posx,
  input  logic [11:0] ball_posy,
  input  logic [3:0]  pl1_score,
  input  logic [3:0]  pl2_score,
  input  logic        flag_point,
  input  logic        end_game,
  input  logic        whistle_play,
  input  logic        conv16to8ready,
  input  logic        tx_done,
  output logic [15:0] data,
  output logic        data_valid,
  output logic        frame_sent
);

  localparam int unsigned CntW = $clog2(FRAME_GAP + 1);
  localparam logic [CntW-1:0] GapLast = CntW'(FRAME_GAP - 1);

  typedef enum logic [1:0] {StGap, StLoad, StSend, StWait} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [4:0][11:0] snap_q, snap_d;
  logic             whistle_q, whistle_d;
  logic [15:0]      data_q, data_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_sent_q, frame_sent_d;
  logic [11:0]      status;
  logic [2:0]       idx_inc;

  assign status  = {pl1_score, pl2_score, 1'b0, flag_point, end_game, whistle_q};
  assign idx_inc = idx_q + 3'd1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    snap_d       = snap_q;
    whistle_d    = whistle_q | whistle_play;
    data_d       = data_q;
    data_valid_d = data_valid_q;
    frame_sent_d = 1'b0;
    unique case (state_q)
      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = StLoad;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLoad: begin
        snap_d       = {status, ball_posy, ball_posx, pl1_posy, pl1_posx};
        // The latched whistle goes into this frame; a pulse arriving now waits for the next.
        whistle_d    = whistle_play;
        idx_d        = 3'd0;
        data_d       = {4'd0, pl1_posx};
        data_valid_d = 1'b1;
        state_d      = StSend;
      end
      StSend: begin
        if (conv16to8ready && data_valid_q) begin
          data_valid_d = 1'b0;
          state_d      = StWait;
        end
      end
      StWait: begin
        if (tx_done) begin
          if (idx_q == 3'd4) begin
            frame_sent_d = 1'b1;
            cnt_d        = '0;
            state_d      = StGap;
          end else begin
            idx_d        = idx_inc;
            data_d       = {1'b0, idx_inc, snap_q[idx_inc]};
            data_valid_d = 1'b1;
            state_d      = StSend;
          end
        end
      end
      default: state_d = StGap;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StGap;
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      snap_q       <= '0;
      whistle_q    <= 1'b0;
      data_q       <= 16'h0000;
      data_valid_q <= 1'b0;
      frame_sent_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      whistle_q    <= whistle_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      frame_sent_q <= frame_sent_d;
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign frame_sent = frame_sent_q;

endmodule

// File: tb/tb_game_state_mux.sv
// Bench for game_state_mux: directed frames from the test plan, then randomized frames,
// all checked cycle by cycle against a transaction-level model of the link protocol.
module tb_game_state_mux;

  localparam int unsigned Gap = 20;

  typedef enum {MGap, MSend, MWait} mphase_e;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] pl1_posx, pl1_posy, ball_posx, ball_posy;
  logic [3:0]  pl1_score, pl2_score;
  logic        flag_point, end_game, whistle_play, conv16to8ready, tx_done;
  logic [15:0] data;
  logic        data_valid, frame_sent;

  always #5 clk = ~clk;

  game_state_mux #(.FRAME_GAP(Gap)) dut (
    .clk            (clk),
    .rst            (rst),
    .pl1_posx       (pl1_posx),
    .pl1_posy       (pl1_posy),
    .ball_posx      (ball_posx),
    .ball_posy      (ball_posy),
    .pl1_score      (pl1_score),
    .pl2_score      (pl2_score),
    .flag_point     (flag_point),
    .end_game       (end_game),
    .whistle_play   (whistle_play),
    .conv16to8ready (conv16to8ready),
    .tx_done        (tx_done),
    .data           (data),
    .data_valid     (data_valid),
    .frame_sent     (frame_sent)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc, load_tick, idx, frame_no, frames_done, tx_cnt, bp_left;
  mphase_e     ph;
  logic [11:0] snap [5];
  logic        wh_pend, exp_dv, exp_fs, ready_prev, tx_prev;
  logic        bp_done, spur_done, post_reset;
  logic [15:0] exp_data;
  logic [15:0] words [$];

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    cyc       = 0;
    load_tick = Gap;
    ph        = MGap;
    idx       = 0;
    wh_pend   = 1'b0;
    exp_dv    = 1'b0;
    exp_fs    = 1'b0;
    exp_data  = 16'h0000;
    tx_cnt    = 0;
    bp_left   = 0;
    tx_done   = 1'b0;
    whistle_play = 1'b0;
    words.delete();
    foreach (snap[i]) snap[i] = 12'h000;
  endtask

  // One clock: advance the protocol model on the edge, then compare the outputs.
  task automatic cycle();
    logic [15:0] data_before;
    data_before = data;
    ready_prev  = conv16to8ready;
    tx_prev     = tx_done;
    @(posedge clk);
    #1;
    cyc++;
    exp_fs = 1'b0;
    case (ph)
      MGap: begin
        if (cyc == load_tick + 1) begin
          idx      = 0;
          exp_data = {4'd0, snap[0]};
          exp_dv   = 1'b1;
          ph       = MSend;
        end
      end
      MSend: begin
        if (ready_prev) begin
          words.push_back(data_before);
          exp_dv = 1'b0;
          ph     = MWait;
          tx_cnt = (frames_done >= 5) ? int'($urandom_range(1, 12)) : 10;
        end
      end
      MWait: begin
        if (tx_prev) begin
          if (idx == 4) begin
            exp_fs    = 1'b1;
            ph        = MGap;
            load_tick = cyc + Gap;
          end else begin
            idx++;
            exp_data = {4'(idx), snap[idx]};
            exp_dv   = 1'b1;
            ph       = MSend;
          end
        end
      end
    endcase
    check_eq("data_valid", 16'(data_valid), 16'(exp_dv));
    check_eq("data", data, exp_data);
    check_eq("frame_sent", 16'(frame_sent), 16'(exp_fs));
  endtask

  task automatic frame_checks();
    logic [15:0] w [5];
    logic [15:0] k1 [5];
    k1 = '{16'h0123, 16'h1456, 16'h2789, 16'h3ABC, 16'h4534};
    check_eq("word_count", 16'(words.size()), 16'd5);
    for (int i = 0; i < 5; i++) begin
      w[i] = (i < words.size()) ? words[i] : 16'hxxxx;
      check_eq("tag_order", 16'(w[i][15:12]), 16'(i));
    end
    if (!post_reset) begin
      case (frames_done)
        1: for (int i = 0; i < 5; i++) check_eq("first_frame_word", w[i], k1[i]);
        2: check_eq("backpressure_word2", w[2], 16'h2789);
        3: begin
          check_eq("coherent_next_word2", w[2], 16'h2001);
          check_eq("whistle_in_gap", 16'(w[4][0]), 16'd1);
        end
        4: check_eq("whistle_cleared", 16'(w[4][0]), 16'd0);
        5: check_eq("whistle_at_load", 16'(w[4][0]), 16'd1);
        default: ;
      endcase
    end
  endtask

  // Inputs for the next clock: converter responder, scenario hooks, random traffic.
  task automatic drive();
    tx_done      = 1'b0;
    whistle_play = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_done = 1'b1;
    end
    if (frame_no == 2 && ph == MWait && idx == 1) ball_posx = 12'h001;
    if (frame_no == 2 && ph == MSend && idx == 2 && !bp_done) begin
      bp_left = 50;
      bp_done = 1'b1;
    end
    if (frames_done == 2 && cyc == load_tick - 5) whistle_play = 1'b1;
    if (frames_done == 3 && cyc == load_tick - 3) tx_done = 1'b1;
    if (frames_done == 3 && cyc == load_tick) whistle_play = 1'b1;
    if (frame_no == 4 && ph == MSend && idx == 0 && !spur_done) begin
      bp_left   = 4;
      tx_done   = 1'b1;
      spur_done = 1'b1;
    end
    if (frames_done >= 5) begin
      if ($urandom_range(0, 3) == 0) begin
        pl1_posx   = 12'($urandom);
        pl1_posy   = 12'($urandom);
        ball_posx  = 12'($urandom);
        ball_posy  = 12'($urandom);
        pl1_score  = 4'($urandom);
        pl2_score  = 4'($urandom);
        flag_point = 1'($urandom);
        end_game   = 1'($urandom);
      end
      if ($urandom_range(0, 39) == 0) whistle_play = 1'b1;
      if (ph != MWait && $urandom_range(0, 29) == 0) tx_done = 1'b1;
    end
    if (bp_left > 0) begin
      conv16to8ready = 1'b0;
      bp_left--;
    end else begin
      conv16to8ready = (frames_done >= 5) ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    // The edge after load_tick is the snapshot edge: capture what is driven now.
    if (ph == MGap && cyc == load_tick) begin
      snap[0] = pl1_posx;
      snap[1] = pl1_posy;
      snap[2] = ball_posx;
      snap[3] = ball_posy;
      snap[4] = {pl1_score, pl2_score, 1'b0, flag_point, end_game, wh_pend};
      wh_pend = whistle_play;
      frame_no++;
      words.delete();
    end else if (whistle_play) begin
      wh_pend = 1'b1;
    end
  endtask

  task automatic step();
    cycle();
    if (exp_fs) begin
      frames_done++;
      frame_checks();
    end
    drive();
  endtask

  initial begin
    int guard;
    int target;
    rst            = 1'b1;
    pl1_posx       = 12'h123;
    pl1_posy       = 12'h456;
    ball_posx      = 12'h789;
    ball_posy      = 12'hABC;
    pl1_score      = 4'd5;
    pl2_score      = 4'd3;
    flag_point     = 1'b1;
    end_game       = 1'b0;
    conv16to8ready = 1'b1;
    frame_no       = 0;
    frames_done    = 0;
    bp_done        = 1'b0;
    spur_done      = 1'b0;
    post_reset     = 1'b0;
    model_reset();
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_data", data, 16'h0000);
    check_eq("reset_valid", 16'(data_valid), 16'd0);
    check_eq("reset_frame_sent", 16'(frame_sent), 16'd0);
    @(negedge clk);
    rst = 1'b1;

    guard = 0;
    while (frames_done < 12 && guard < 20000) begin
      step();
      guard++;
    end
    check_eq("frames_done", 16'(frames_done), 16'd12);

    guard = 0;
    while (!(ph == MWait && idx == 3) && guard < 2000) begin
      step();
      guard++;
    end
    check_eq("reach_word3_wait", 16'(idx), 16'd3);
    rst = 1'b0;
    #1;
    check_eq("async_rst_data", data, 16'h0000);
    check_eq("async_rst_valid", 16'(data_valid), 16'd0);
    check_eq("async_rst_frame_sent", 16'(frame_sent), 16'd0);
    model_reset();
    post_reset     = 1'b1;
    conv16to8ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    target = frames_done + 1;
    guard  = 0;
    while (frames_done < target && guard < 2000) begin
      step();
      guard++;
    end
    check_eq("post_reset_frame", 16'(frames_done), 16'(target));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
